// File: rtl/gpr_access_pkg.sv
// Shared types and helpers for the GPR access arbiter.
// FSM encoding, idx field slots, GPR address packing.
package gpr_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } arb_state_t;

  // idx is {a,b,c}; slot n sits at [n*REG_W +: REG_W]
  localparam int A_SLOT = 2;
  localparam int B_SLOT = 1;
  localparam int C_SLOT = 0;
  localparam int N_SLOT = 3;

  localparam int PK_W = 64;
  typedef logic [PK_W-1:0] pk_t;

  function automatic pk_t field_mask(input int w);
    return (pk_t'(1) << w) - pk_t'(1);
  endfunction

  function automatic pk_t field(
    input pk_t idx,
    input int  slot,
    input int  reg_w
  );
    return (idx >> (slot * reg_w)) & field_mask(reg_w);
  endfunction

  // Write format: target a, zero-extended
  function automatic pk_t wr_addr(
    input pk_t idx,
    input int  reg_w
  );
    return field(idx, A_SLOT, reg_w);
  endfunction

  // Read format: {a,b,c} left-justified, low bits 0
  function automatic pk_t rd_addr(
    input pk_t idx,
    input int  reg_w,
    input int  addr_w
  );
    pk_t pk;
    pk = (field(idx, A_SLOT, reg_w) << (A_SLOT * reg_w))
       | (field(idx, B_SLOT, reg_w) << (B_SLOT * reg_w))
       | (field(idx, C_SLOT, reg_w) << (C_SLOT * reg_w));
    return pk << (addr_w - N_SLOT * reg_w);
  endfunction

endpackage

// File: rtl/gpr_rr_pick.sv
// Combinational winner pick: (req, ptr) -> one-hot pick + index.
// GPR_ARB_FIXED_PRIO_EN: lowest index wins, ptr ignored.
module gpr_rr_pick
  import gpr_access_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PTR_W-1:0] pick_idx
);

  logic found;

`ifdef GPR_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = PTR_W'(i);
      end
    end
  end
`else
  int j;

  // search starts one past the last winner
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    j        = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        pick[j]  = 1'b1;
        pick_idx = PTR_W'(j);
      end
    end
  end
`endif

endmodule

// File: rtl/gpr_access_arbiter.sv
// GPR access arbiter: shares one GPR among N_REQ requesters,
// one op at a time. Ports: req_i/we_i/idx_i/wdata_i in,
// gnt_o/rvalid_o/rdata_o/busy_o out, gpr_* pins to the GPR.
// Option macro: GPR_ARB_FIXED_PRIO_EN (fixed priority pick).
module gpr_access_arbiter
  import gpr_access_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12,
  parameter int REG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          we_i,
  input  logic [N_REQ*3*REG_W-1:0]  idx_i,
  input  logic [N_REQ*DATA_W-1:0]   wdata_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      busy_o,
  output logic [ADDR_W-1:0]         gpr_address,
  output logic [DATA_W-1:0]         gpr_data_in,
  input  logic [DATA_W-1:0]         gpr_data_out,
  output logic                      gpr_rd,
  output logic                      gpr_wr
);

  localparam int IDX_W = 3 * REG_W;
  localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

  arb_state_t        state, state_d;
  logic [PTR_W-1:0]  ptr, ptr_d;
  logic [N_REQ-1:0]  win, win_d;
  logic              we_q, we_d;

  logic [N_REQ-1:0]  gnt_d, rvalid_d;
  logic [DATA_W-1:0] rdata_d, din_d;
  logic [ADDR_W-1:0] addr_d;
  logic              rd_d, wr_d, busy_d;

  logic [N_REQ-1:0]  pick;
  logic [PTR_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  int                sel;

  gpr_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req      (req_i),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    sel       = int'(pick_idx);
    sel_we    = we_i[sel];
    sel_idx   = idx_i[sel*IDX_W +: IDX_W];
    sel_wdata = wdata_i[sel*DATA_W +: DATA_W];
  end

  // Pin values are computed one cycle ahead so every
  // output comes straight from a flop.
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    win_d    = win;
    we_d     = we_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_o;
    addr_d   = '0;
    din_d    = '0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_ISSUE;
          ptr_d   = pick_idx;
          win_d   = pick;
          we_d    = sel_we;
          gnt_d   = pick;
          if (sel_we) begin
            wr_d   = 1'b1;
            addr_d = ADDR_W'(wr_addr(pk_t'(sel_idx), REG_W));
            din_d  = sel_wdata;
          end else begin
            rd_d   = 1'b1;
            addr_d = ADDR_W'(rd_addr(pk_t'(sel_idx),
                                     REG_W, ADDR_W));
          end
        end
      end
      ST_ISSUE: begin
        state_d = we_q ? ST_IDLE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rdata_d  = gpr_data_out;
        rvalid_d = win;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= PTR_W'(N_REQ - 1);
      win         <= '0;
      we_q        <= 1'b0;
      gnt_o       <= '0;
      rvalid_o    <= '0;
      rdata_o     <= '0;
      busy_o      <= 1'b0;
      gpr_address <= '0;
      gpr_data_in <= '0;
      gpr_rd      <= 1'b0;
      gpr_wr      <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      win         <= win_d;
      we_q        <= we_d;
      gnt_o       <= gnt_d;
      rvalid_o    <= rvalid_d;
      rdata_o     <= rdata_d;
      busy_o      <= busy_d;
      gpr_address <= addr_d;
      gpr_data_in <= din_d;
      gpr_rd      <= rd_d;
      gpr_wr      <= wr_d;
    end
  end

endmodule

// File: tb/tb_gpr_access_arbiter.sv
// Directed bench for gpr_access_arbiter with a small GPR model.
// Hand-computed expectations; one summary line at the end.
module tb_gpr_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_i, we_i;
  logic [23:0] idx_i;
  logic [27:0] wdata_i;
  logic [1:0]  gnt_o, rvalid_o;
  logic [13:0] rdata_o;
  logic        busy_o;
  logic [11:0] gpr_address;
  logic [13:0] gpr_data_in;
  logic [13:0] gpr_data_out;
  logic        gpr_rd, gpr_wr;

  int n_cmp = 0;
  int n_err = 0;
  int both_cnt = 0;

  logic [13:0] mem [16];

  always #5 clk = ~clk;

  gpr_access_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .we_i         (we_i),
    .idx_i        (idx_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .gpr_address  (gpr_address),
    .gpr_data_in  (gpr_data_in),
    .gpr_data_out (gpr_data_out),
    .gpr_rd       (gpr_rd),
    .gpr_wr       (gpr_wr)
  );

  // GPR: registered read of R[a]+R[b]+R[c], no reset
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    gpr_data_out = '0;
  end

  always @(posedge clk) begin
    if (gpr_wr) mem[gpr_address[3:0]] <= gpr_data_in;
    if (gpr_rd)
      gpr_data_out <= mem[gpr_address[11:8]]
                    + mem[gpr_address[7:4]]
                    + mem[gpr_address[3:0]];
  end

  always @(negedge clk)
    if (gpr_rd && gpr_wr) both_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input int r, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!gnt_o[r] && lat < 8);
  endtask

  task automatic wr(input int r, input logic [3:0] a,
                    input logic [13:0] d,
                    input logic [11:0] ea);
    int lat;
    logic [1:0] oh;
    oh = 2'b01 << r;
    req_i[r] = 1'b1;
    we_i[r]  = 1'b1;
    idx_i[r*12 +: 12]   = {a, 8'h00};
    wdata_i[r*14 +: 14] = d;
    wait_gnt(r, lat);
    chk("wr_lat", lat, 1);
    chk("wr_gnt", gnt_o, oh);
    chk("wr_pins", {gpr_wr, gpr_rd}, 2'b10);
    chk("wr_addr", gpr_address, ea);
    chk("wr_din", gpr_data_in, d);
    chk("wr_busy", busy_o, 1);
    req_i[r] = 1'b0;
    @(negedge clk);
    chk("wr_done", {busy_o, gpr_wr, gnt_o}, 0);
  endtask

  task automatic rd(input int r, input logic [3:0] a,
                    input logic [3:0] b, input logic [3:0] c,
                    input logic [11:0] ea,
                    input logic [13:0] ed);
    int lat;
    logic [1:0] oh;
    oh = 2'b01 << r;
    req_i[r] = 1'b1;
    we_i[r]  = 1'b0;
    idx_i[r*12 +: 12] = {a, b, c};
    wait_gnt(r, lat);
    chk("rd_lat", lat, 1);
    chk("rd_gnt", gnt_o, oh);
    chk("rd_pins", {gpr_wr, gpr_rd}, 2'b01);
    chk("rd_addr", gpr_address, ea);
    chk("rd_din", gpr_data_in, 0);
    req_i[r] = 1'b0;
    @(negedge clk);
    chk("rd_t2", {rvalid_o, busy_o, gnt_o, gpr_rd}, 6'b001000);
    @(negedge clk);
    chk("rd_rvalid", rvalid_o, oh);
    chk("rd_data", rdata_o, ed);
    chk("rd_busy3", busy_o, 0);
    @(negedge clk);
    chk("rd_pulse", rvalid_o, 0);
    chk("rd_hold", rdata_o, ed);
  endtask

  initial begin
    int lat;
    int cnt;
    logic [1:0] exp_seq [4];
`ifdef GPR_ARB_FIXED_PRIO_EN
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    rst_n   = 1'b0;
    req_i   = '0;
    we_i    = '0;
    idx_i   = '0;
    wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", gpr_address, 0);
    chk("rst_din", gpr_data_in, 0);
    chk("rst_rdwr", {gpr_rd, gpr_wr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    wr(0, 4'd1, 14'h0005, 12'h001);
    wr(0, 4'd2, 14'h0010, 12'h002);
    wr(0, 4'd3, 14'h0100, 12'h003);
    rd(0, 4'd1, 4'd2, 4'd3, 12'h123, 14'h0115);

    wr(0, 4'd4, 14'h3FFF, 12'h004);
    wr(0, 4'd5, 14'h0001, 12'h005);
    wr(0, 4'd6, 14'h0000, 12'h006);
    rd(0, 4'd4, 4'd5, 4'd6, 12'h456, 14'h0000);

    rd(1, 4'd1, 4'd2, 4'd3, 12'h123, 14'h0115);

    // reset while the read sits in CAPTURE
    req_i[1] = 1'b1;
    we_i[1]  = 1'b0;
    idx_i[12 +: 12] = 12'h456;
    wait_gnt(1, lat);
    chk("ra_gnt", gnt_o, 2'b10);
    req_i[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("ra_rvalid", rvalid_o, 0);
    chk("ra_rdata", rdata_o, 0);
    chk("ra_busy", busy_o, 0);
    chk("ra_pins", {gpr_rd, gpr_wr, gnt_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ra_late", rvalid_o, 0);
    rd(0, 4'd1, 4'd2, 4'd3, 12'h123, 14'h0115);

    // req1 withdrawn before it could be sampled
    req_i[0] = 1'b1;
    we_i[0]  = 1'b1;
    idx_i[0 +: 12]   = 12'hA00;
    wdata_i[0 +: 14] = 14'h0022;
    wait_gnt(0, lat);
    chk("wd_gnt0", gnt_o, 2'b01);
    req_i[0] = 1'b0;
    req_i[1] = 1'b1;
    we_i[1]  = 1'b1;
    idx_i[12 +: 12]   = 12'h900;
    wdata_i[14 +: 14] = 14'h3333;
    @(negedge clk);
    req_i[1] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (gnt_o[1] || gpr_wr || gpr_rd) cnt++;
    end
    chk("wd_access", cnt, 0);
    chk("wd_mem9", mem[9], 14'h0000);
    chk("wd_mem10", mem[10], 14'h0022);

    // both requesting writes from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    we_i  = 2'b11;
    idx_i = {12'h800, 12'h700};
    wdata_i = {14'h1555, 14'h0AAA};
    req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_gnt", gnt_o, exp_seq[k]);
      chk("rr_busy1", busy_o, 1);
      @(negedge clk);
      chk("rr_gap", {gnt_o, busy_o}, 0);
    end
    req_i[0] = 1'b0;
    @(negedge clk);
    chk("rr_req1", gnt_o, 2'b10);
    req_i[1] = 1'b0;
    @(negedge clk);
    chk("rr_mem7", mem[7], 14'h0AAA);
    chk("rr_mem8", mem[8], 14'h1555);

    chk("rdwr_excl", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
